// File: rtl/axil_reg_slave.sv
// ============================================================================
// Module   : axil_reg_slave
// Brief    : AXI4-Lite slave bank of NUM_REGS 32-bit registers with byte
//            strobes, register outputs and per-register write pulses.
//            Define AXIL_SLVERR_EN to reject out-of-range accesses with
//            SLVERR; otherwise the word index aliases modulo NUM_REGS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_slave #(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int         c_ADDR_LSB = 2;
  localparam int         c_IDX_W    = $clog2(NUM_REGS);
  localparam logic [4:0] c_NUM_REGS = 5'(NUM_REGS);
  localparam logic [1:0] c_OKAY     = 2'b00;
  localparam logic [1:0] c_SLVERR   = 2'b10;

  localparam logic [1:0] c_WR_IDLE  = 2'd0;
  localparam logic [1:0] c_WR_AW    = 2'd1;
  localparam logic [1:0] c_WR_W     = 2'd2;
  localparam logic [1:0] c_WR_RESP  = 2'd3;

  logic [1:0]          r_wr_state;
  logic [1:0]          w_wr_state_nxt;
  logic                r_ready_en;
  logic [3:0]          r_aw_word;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_regs [NUM_REGS];
  logic [1:0]          r_bresp;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic                r_rvalid;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_commit;
  logic [3:0]          w_wr_word;
  logic [3:0]          w_rd_word;
  logic [31:0]         w_wr_data;
  logic [3:0]          w_wr_strb;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [1:0]          w_wr_resp;
  logic [1:0]          w_rd_resp;
  logic                w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_WIDTH-1:c_ADDR_LSB+4], S_AXI_AWADDR[c_ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_WIDTH-1:c_ADDR_LSB+4], S_AXI_ARADDR[c_ADDR_LSB-1:0]};

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Commit as soon as both halves exist, whether latched earlier or arriving now
  assign w_commit = (w_aw_hs || (r_wr_state == c_WR_AW)) && (w_w_hs || (r_wr_state == c_WR_W));

  assign w_wr_word = (r_wr_state == c_WR_AW) ? r_aw_word : S_AXI_AWADDR[c_ADDR_LSB+3:c_ADDR_LSB];
  assign w_wr_data = (r_wr_state == c_WR_W) ? r_wdata : S_AXI_WDATA;
  assign w_wr_strb = (r_wr_state == c_WR_W) ? r_wstrb : S_AXI_WSTRB;
  assign w_rd_word = S_AXI_ARADDR[c_ADDR_LSB+3:c_ADDR_LSB];

`ifdef AXIL_SLVERR_EN
  assign w_wr_ok   = ({1'b0, w_wr_word} < c_NUM_REGS);
  assign w_rd_ok   = ({1'b0, w_rd_word} < c_NUM_REGS);
  assign w_wr_idx  = c_IDX_W'(w_wr_word);
  assign w_rd_idx  = c_IDX_W'(w_rd_word);
  assign w_wr_resp = w_wr_ok ? c_OKAY : c_SLVERR;
  assign w_rd_resp = w_rd_ok ? c_OKAY : c_SLVERR;
`else
  assign w_wr_ok   = 1'b1;
  assign w_rd_ok   = 1'b1;
  assign w_wr_idx  = c_IDX_W'({1'b0, w_wr_word} % c_NUM_REGS);
  assign w_rd_idx  = c_IDX_W'({1'b0, w_rd_word} % c_NUM_REGS);
  assign w_wr_resp = c_OKAY;
  assign w_rd_resp = c_OKAY;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_wr_state <= c_WR_IDLE;
    else                r_wr_state <= w_wr_state_nxt;
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      c_WR_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wr_state_nxt = c_WR_RESP;
        else if (w_aw_hs)      w_wr_state_nxt = c_WR_AW;
        else if (w_w_hs)       w_wr_state_nxt = c_WR_W;
      end
      c_WR_AW:   if (w_w_hs)       w_wr_state_nxt = c_WR_RESP;
      c_WR_W:    if (w_aw_hs)      w_wr_state_nxt = c_WR_RESP;
      c_WR_RESP: if (S_AXI_BREADY) w_wr_state_nxt = c_WR_IDLE;
      default:                     w_wr_state_nxt = c_WR_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = r_ready_en && ((r_wr_state == c_WR_IDLE) || (r_wr_state == c_WR_W));
    S_AXI_WREADY  = r_ready_en && ((r_wr_state == c_WR_IDLE) || (r_wr_state == c_WR_AW));
    S_AXI_BVALID  = (r_wr_state == c_WR_RESP);
  end

  // Keeps every READY low through reset and for the release edge itself
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_ready_en <= 1'b0;
    else                r_ready_en <= 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_aw_word <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_aw_hs) r_aw_word <= S_AXI_AWADDR[c_ADDR_LSB+3:c_ADDR_LSB];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_bresp    <= c_OKAY;
      r_wr_pulse <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bresp <= w_wr_resp;
        if (w_wr_ok) begin
          r_wr_pulse[w_wr_idx] <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the registers before this edge's write lands
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_ok ? r_regs[w_rd_idx] : '0;
      r_rresp  <= w_rd_resp;
    end else if (S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_ARREADY = r_ready_en && !r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_BRESP   = r_bresp;
  assign wr_pulse      = r_wr_pulse;

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
      assign reg_out[32*k +: 32] = r_regs[k];
    end
  endgenerate

endmodule

`default_nettype wire
